cpu_mc_control: RTL and testbench

CPU_MC_CONTROL -- requirements
Module: cpu_mc_control

---
 rtl/cpu_mc_control.sv | 128 ++++++++++++
 tb/tb_cpu_mc_control.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc_control.sv
// cpu_mc_control: multi-cycle LEGv8-subset control FSM with bounded memory waits
// and saturating cycle/instruction performance counters.
module cpu_mc_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [10:0]      inst31_21,
    input  logic             i_ready,
    input  logic             d_ready,
    input  logic             zero,
    output logic             i_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             Reg2Loc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrc,
    output logic             RegWrite,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR} state_t;
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [10:0]      op_q, op_d;
    logic [7:0]       wait_q, wait_d;
    logic             halted_q, halted_d, illegal_q, illegal_d, timeout_q, timeout_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;

    logic is_ldur, is_stur, is_rtype, is_addi, is_cbz, is_cbnz, is_b, is_halt, is_br, mem_op, legal;
    logic in_exec, in_mem, in_wb, waiting, expired;

    assign is_ldur  = op_q == 11'b11111000010;
    assign is_stur  = op_q == 11'b11111000000;
    assign is_rtype = op_q == 11'b10001011000 || op_q == 11'b11001011000 ||
                      op_q == 11'b10001010000 || op_q == 11'b10101010000;
    assign is_addi  = op_q[10:1] == 10'b1001000100;
    assign is_cbz   = op_q[10:3] == 8'b10110100;
    assign is_cbnz  = op_q[10:3] == 8'b10110101;
    assign is_b     = op_q[10:5] == 6'b000101;
    assign is_halt  = op_q == 11'b11111111111;
    assign is_br    = is_b || is_cbz || is_cbnz;
    assign mem_op   = is_ldur || is_stur;
    assign legal    = is_rtype || is_addi || mem_op || is_br || is_halt;

    assign in_exec = state_q == EXEC;
    assign in_mem  = state_q == MEM;
    assign in_wb   = state_q == WB;

    always_comb begin
        i_req    = state_q == FETCH;
        ir_write = i_req && i_ready;
        ALUOp    = !in_exec ? 2'b00 : (is_rtype || is_addi) ? 2'b10 : (is_cbz || is_cbnz) ? 2'b01 : 2'b00;
        ALUSrc   = ((in_exec || in_mem) && mem_op) ? 2'b01 : (in_exec && is_addi) ? 2'b10 : 2'b00;
        Reg2Loc  = (in_exec && (is_stur || is_cbz || is_cbnz)) || (in_mem && is_stur);
        MemRead  = in_mem && is_ldur;
        MemWrite = in_mem && is_stur;
        pc_write = (in_exec && is_br) || (MemWrite && d_ready) || in_wb;
        pc_src   = in_exec && (is_b || (is_cbz && zero) || (is_cbnz && !zero));
        RegWrite = in_wb;
        MemtoReg = in_wb && is_ldur;
    end

    // A request that is still unanswered after MEM_TIMEOUT wait cycles is fatal
    assign waiting = (i_req && !i_ready) || (in_mem && !d_ready);
    assign expired = waiting && wait_q == TMO;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = start ? FETCH : IDLE;
            FETCH:  state_d = i_ready ? DECODE : expired ? ERROR : FETCH;
            DECODE: state_d = !legal ? ERROR : is_halt ? HALT : EXEC;
            EXEC:   state_d = mem_op ? MEM : is_br ? FETCH : WB;
            MEM:    state_d = d_ready ? (is_ldur ? WB : FETCH) : expired ? ERROR : MEM;
            WB:     state_d = FETCH;
            HALT:   state_d = HALT;
            ERROR:  state_d = ERROR;
        endcase
        op_d      = ir_write ? inst31_21 : op_q;
        wait_d    = waiting ? wait_q + 8'd1 : 8'd0;
        halted_d  = halted_q || (state_q == DECODE && legal && is_halt);
        illegal_d = illegal_q || (state_q == DECODE && !legal);
        timeout_d = timeout_q || expired;
        cyc_d     = (state_q inside {FETCH, DECODE, EXEC, MEM, WB} && !(&cyc_q)) ? cyc_q + CNT_W'(1) : cyc_q;
        ins_d     = (pc_write && !(&ins_q)) ? ins_q + CNT_W'(1) : ins_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
            ins_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
        end
    end

    assign state       = state_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
endmodule

// File: tb/tb_cpu_mc_control.sv
// tb_cpu_mc_control: directed vector table, corner-case sequences and random
// stimulus checked cycle by cycle against an instruction-class reference model.
module tb_cpu_mc_control;
    localparam int T = 4;
    localparam int W = 4;
    localparam int MAXC = (1 << W) - 1;
    localparam int C_R = 0, C_ADDI = 1, C_LD = 2, C_ST = 3, C_CBZ = 4, C_CBNZ = 5, C_B = 6, C_HALT = 7, C_ILL = 8;
    localparam logic [10:0] OP_ADD = 11'b10001011000, OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ = 11'b10110100101, OP_CBNZ = 11'b10110101010, OP_B = 11'b00010110011;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, i_ready = 1'b0, d_ready = 1'b0, zero = 1'b0;
    logic [10:0] inst = '0;
    logic i_req, ir_write, pc_write, pc_src, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [1:0] ALUOp, ALUSrc;
    logic [2:0] state;
    logic halted, illegal, timeout;
    logic [W-1:0] cycle_count, instr_count;

    int checks = 0, errors = 0;
    int m_st, m_wait, m_cyc, m_ins;
    logic [10:0] m_op;
    logic m_halt, m_ill, m_tmo;

    cpu_mc_control #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst31_21(inst), .i_ready(i_ready),
        .d_ready(d_ready), .zero(zero), .i_req(i_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .Reg2Loc(Reg2Loc), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .state(state),
        .halted(halted), .illegal(illegal), .timeout(timeout), .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int cls(input logic [10:0] o);
        casez (o)
            11'b11111000010: return C_LD;
            11'b11111000000: return C_ST;
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: return C_R;
            11'b1001000100?: return C_ADDI;
            11'b10110100???: return C_CBZ;
            11'b10110101???: return C_CBNZ;
            11'b000101?????: return C_B;
            11'b11111111111: return C_HALT;
            default:         return C_ILL;
        endcase
    endfunction

    // {i_req, ir_write, pc_write, pc_src, Reg2Loc, MemRead, MemWrite, MemtoReg, ALUOp, ALUSrc, RegWrite}
    function automatic logic [12:0] exp_ctrl();
        int c = cls(m_op);
        logic ex = m_st == 3, me = m_st == 4, wb = m_st == 5;
        logic br = c == C_B || c == C_CBZ || c == C_CBNZ;
        logic [1:0] aop = 2'd0, asrc = 2'd0;
        logic r2l = 1'b0;
        if (ex || me)
            case (c)
                C_R:          aop = 2'd2;
                C_ADDI:       begin aop = 2'd2; asrc = 2'd2; end
                C_LD:         asrc = 2'd1;
                C_ST:         begin asrc = 2'd1; r2l = 1'b1; end
                C_CBZ, C_CBNZ: begin aop = 2'd1; r2l = 1'b1; end
                default:      ;
            endcase
        return {m_st == 1, m_st == 1 && i_ready, (ex && br) || (me && c == C_ST && d_ready) || wb,
                ex && (c == C_B || (c == C_CBZ && zero) || (c == C_CBNZ && !zero)),
                r2l, me && c == C_LD, me && c == C_ST, wb && c == C_LD, aop, asrc, wb};
    endfunction

    function automatic logic [12:0] ctrl_dut();
        return {i_req, ir_write, pc_write, pc_src, Reg2Loc, MemRead, MemWrite, MemtoReg, ALUOp, ALUSrc, RegWrite};
    endfunction

    function automatic logic [31:0] obs_dut();
        return {5'd0, state, ctrl_dut(), halted, illegal, timeout, cycle_count, instr_count};
    endfunction

    function automatic logic [31:0] obs_model();
        return {5'd0, 3'(m_st), exp_ctrl(), m_halt, m_ill, m_tmo, 4'(m_cyc), 4'(m_ins)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_wait = 0; m_cyc = 0; m_ins = 0; m_op = '0; m_halt = 0; m_ill = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        int c = cls(m_op);
        logic [12:0] e = exp_ctrl();
        int nst = m_st;
        case (m_st)
            0: nst = start ? 1 : 0;
            1: nst = i_ready ? 2 : (m_wait == T ? 7 : 1);
            2: nst = c == C_ILL ? 7 : (c == C_HALT ? 6 : 3);
            3: nst = (c == C_LD || c == C_ST) ? 4 : (c == C_B || c == C_CBZ || c == C_CBNZ) ? 1 : 5;
            4: nst = d_ready ? (c == C_LD ? 5 : 1) : (m_wait == T ? 7 : 4);
            5: nst = 1;
            default: nst = m_st;
        endcase
        if (m_st == 2 && c == C_ILL) m_ill = 1;
        if (m_st == 2 && c == C_HALT) m_halt = 1;
        if ((m_st == 1 || m_st == 4) && nst == 7) m_tmo = 1;
        if (m_st == 1 && i_ready) m_op = inst;
        m_wait = (nst == m_st && (m_st == 1 || m_st == 4)) ? m_wait + 1 : 0;
        if (m_st >= 1 && m_st <= 5 && m_cyc < MAXC) m_cyc++;
        if (e[10] && m_ins < MAXC) m_ins++;
        m_st = nst;
    endtask

    task automatic sample();
        @(negedge clk);
        check("model", obs_dut(), obs_model());
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic step(input logic s, input logic [10:0] op, input logic ir, input logic dr, input logic z);
        start = s; inst = op; i_ready = ir; d_ready = dr; zero = z;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; i_ready = 0; d_ready = 0; zero = 0; inst = '0;
        model_reset();
        #1;
        check("reset", obs_dut(), obs_model());
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    function automatic logic [10:0] rand_op();
        logic [10:0] r = 11'($urandom);
        case ($urandom_range(0, 11))
            0: return 11'b11111000010;
            1: return 11'b11111000000;
            2: return 11'b10001011000;
            3: return 11'b11001011000;
            4: return 11'b10001010000;
            5: return 11'b10101010000;
            6: return {10'b1001000100, r[0]};
            7: return {8'b10110100, r[2:0]};
            8: return {8'b10110101, r[2:0]};
            9: return {6'b000101, r[4:0]};
            10: return ($urandom_range(0, 3) == 0) ? 11'h7FF : r;
            default: return r;
        endcase
    endfunction

    typedef struct {
        logic        st;
        logic [10:0] op;
        logic        ir, dr;
        logic [2:0]  est;
        logic [12:0] ectl;
        int          ecyc, eins;
    } vec_t;

    initial begin
        vec_t tbl[14];
        logic [10:0] bop[5] = '{OP_CBZ, OP_CBZ, OP_CBNZ, OP_CBNZ, OP_B};
        logic bz[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic bsrc[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int stuck, slow;

        tbl[0]  = '{1'b1, 11'd0,   1'b0, 1'b0, 3'd0, 13'b0_0_0_0_0_0_0_0_00_00_0, 0, 0};
        tbl[1]  = '{1'b0, OP_ADD,  1'b1, 1'b0, 3'd1, 13'b1_1_0_0_0_0_0_0_00_00_0, 0, 0};
        tbl[2]  = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd2, 13'b0_0_0_0_0_0_0_0_00_00_0, 1, 0};
        tbl[3]  = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd3, 13'b0_0_0_0_0_0_0_0_10_00_0, 2, 0};
        tbl[4]  = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd5, 13'b0_0_1_0_0_0_0_0_00_00_1, 3, 0};
        tbl[5]  = '{1'b0, OP_LDUR, 1'b1, 1'b0, 3'd1, 13'b1_1_0_0_0_0_0_0_00_00_0, 4, 1};
        tbl[6]  = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd2, 13'b0_0_0_0_0_0_0_0_00_00_0, 5, 1};
        tbl[7]  = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd3, 13'b0_0_0_0_0_0_0_0_00_01_0, 6, 1};
        tbl[8]  = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd4, 13'b0_0_0_0_0_1_0_0_00_01_0, 7, 1};
        tbl[9]  = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd4, 13'b0_0_0_0_0_1_0_0_00_01_0, 8, 1};
        tbl[10] = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd4, 13'b0_0_0_0_0_1_0_0_00_01_0, 9, 1};
        tbl[11] = '{1'b0, 11'd0,   1'b0, 1'b1, 3'd4, 13'b0_0_0_0_0_1_0_0_00_01_0, 10, 1};
        tbl[12] = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd5, 13'b0_0_1_0_0_0_0_1_00_00_1, 11, 1};
        tbl[13] = '{1'b0, 11'd0,   1'b0, 1'b0, 3'd1, 13'b1_0_0_0_0_0_0_0_00_00_0, 12, 2};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st; inst = tbl[i].op; i_ready = tbl[i].ir; d_ready = tbl[i].dr; zero = 0;
            sample();
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].est));
            check($sformatf("tbl%0d_ctrl", i), 32'(ctrl_dut()), 32'(tbl[i].ectl));
            check($sformatf("tbl%0d_cnt", i), {cycle_count, instr_count}, {4'(tbl[i].ecyc), 4'(tbl[i].eins)});
            advance();
        end

        // Conditional and unconditional branches
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, bop[i], 1, 0, 0);
            step(0, 0, 0, 0, 0);
            zero = bz[i];
            sample();
            check($sformatf("br%0d_pcw", i), 32'(pc_write), 32'd1);
            check($sformatf("br%0d_src", i), 32'(pc_src), 32'(bsrc[i]));
            check($sformatf("br%0d_rw", i), 32'(RegWrite), 32'd0);
            advance();
        end

        // Fetch ready in the last allowed wait cycle, then a data timeout on LDUR
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < T; i++) step(0, OP_ADD, 0, 0, 0);
        step(0, OP_ADD, 1, 0, 0);
        sample();
        check("late_fetch_ok", 32'(state), 32'd2);
        advance();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, OP_LDUR, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i <= T; i++) step(0, 0, 0, 0, 0);
        sample();
        check("mem_timeout", {29'd0, state}, 32'd7);
        check("mem_timeout_flag", 32'(timeout), 32'd1);
        advance();

        // Fetch that never completes
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i <= T; i++) step(0, OP_ADD, 0, 0, 0);
        sample();
        check("fetch_timeout", {28'd0, timeout, state}, {28'd0, 1'b1, 3'd7});
        advance();

        // Illegal opcode is sticky until reset
        do_reset();
        step(1, 0, 0, 0, 0);
        step(0, 11'd0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, OP_ADD, 1, 1, 0);
        sample();
        check("illegal_sticky", {28'd0, illegal, state}, {28'd0, 1'b1, 3'd7});
        advance();
        do_reset();
        check("illegal_cleared", 32'(illegal), 32'd0);

        // HALT freezes the cycle counter
        step(1, 0, 0, 0, 0);
        step(0, 11'h7FF, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
        sample();
        check("halt_state", {28'd0, halted, state}, {28'd0, 1'b1, 3'd6});
        check("halt_cycles", 32'(cycle_count), 32'd2);
        advance();

        // Asynchronous reset in the middle of a store
        do_reset();
        step(1, 0, 0, 0, 0);
        step(0, OP_STUR, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        sample();
        check("stur_memwrite", 32'(MemWrite), 32'd1);
        #1 rst_n = 0;
        #1;
        check("async_rst", {28'd0, MemWrite, state}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        step(0, OP_ADD, 1, 1, 0);
        step(0, OP_ADD, 1, 1, 0);

        // Randomized run against the reference model
        do_reset();
        stuck = 0;
        slow = 0;
        for (int n = 0; n < 4000; n++) begin
            if ((m_st >= 6 && ++stuck > 3) || $urandom_range(0, 499) == 0) begin
                do_reset();
                stuck = 0;
                slow = $urandom_range(0, 2) == 0;
            end
            start = $urandom_range(0, 3) == 0;
            inst = (m_st == 1) ? rand_op() : 11'($urandom);
            i_ready = slow ? $urandom_range(0, 4) == 0 : $urandom_range(0, 2) != 0;
            d_ready = slow ? $urandom_range(0, 4) == 0 : $urandom_range(0, 2) != 0;
            zero = 1'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
